// File: rtl/ctu_rst_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : ctu_rst_pkg                                                  |
// | Description : Shared types and constants for the cluster reset sequencer. |
// |               Holds the sequencer state encoding, the fixed length of the |
// |               reset-assert phase, and a small integer max helper used to  |
// |               size the hold counter.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package ctu_rst_pkg;

  // Number of gclk cycles spent in the reset-assert phase.
  localparam int RST_ASSERT_CYC = 4;

  typedef enum logic [2:0] {
    ST_RST_ASSERT = 3'd0,
    ST_CKEN_RAMP  = 3'd1,
    ST_RST_HOLD   = 3'd2,
    ST_RUN        = 3'd3,
    ST_WMR        = 3'd4,
    ST_DBG        = 3'd5
  } seq_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ctu_rst_hold_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctu_rst_hold_cnt                                             |
// | Description : Loadable down-counter with terminal-count flag. Counts down |
// |               by one each cycle and saturates at zero.                     |
// | Ports       : gclk      - clock, rising edge                               |
// |               arst      - asynchronous active-high reset (count -> 0)      |
// |               ld_i      - load ld_val_i this cycle                         |
// |               ld_val_i  - value to load                                    |
// |               cnt_o     - current count                                    |
// |               tc_o      - high while count is zero                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ctu_rst_hold_cnt #(
  parameter int WIDTH = 6
) (
  input  logic             gclk,
  input  logic             arst,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ld_i) begin
      cnt_d = ld_val_i;
    end else if (cnt_q != '0) begin
      // Saturate at zero so an idle counter never wraps.
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/ctu_cluster_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ctu_cluster_rst_seq                                          |
// | Description : Cluster reset / clock-enable sequencer. On power-on it      |
// |               asserts reset, ramps per-cluster clock enables one at a     |
// |               time, holds reset, then releases into RUN. Supports warm    |
// |               reset and debug-init from RUN. All outputs are registered.  |
// | Ports       : gclk          - sole clock, rising edge                      |
// |               arst          - asynchronous active-high reset               |
// |               pwron_rst_req - restart full power-on sequence (pulse)       |
// |               wmr_req       - warm reset request (pulse)                   |
// |               dbginit_req   - debug init request (pulse)                   |
// |               cken_mask     - per-cluster enable permission                |
// |               grst_l        - global reset, active-low                     |
// |               gdbginit_l    - global debug init, active-low                |
// |               cluster_cken  - per-cluster clock enable                     |
// |               seq_busy      - high in every state but RUN                  |
// |               seq_done      - one-cycle pulse on first RUN cycle           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ctu_cluster_rst_seq
  import ctu_rst_pkg::*;
#(
  parameter int NUM_CLUSTERS = 8,
  parameter int CKEN_STAGGER = 4,
  parameter int RST_HOLD     = 32,
  parameter int DBG_HOLD     = 16
) (
  input  logic                    gclk,
  input  logic                    arst,
  input  logic                    pwron_rst_req,
  input  logic                    wmr_req,
  input  logic                    dbginit_req,
  input  logic [NUM_CLUSTERS-1:0] cken_mask,
  output logic                    grst_l,
  output logic                    gdbginit_l,
  output logic [NUM_CLUSTERS-1:0] cluster_cken,
  output logic                    seq_busy,
  output logic                    seq_done
);

  localparam int RAMP_LEN = NUM_CLUSTERS * CKEN_STAGGER;
  localparam int CNT_MAX  = max2(max2(RST_HOLD, DBG_HOLD), max2(RAMP_LEN, RST_ASSERT_CYC));
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  // Load values are length-1: the counter reaches zero on the last cycle.
  localparam logic [CNT_W-1:0] LD_ASSERT = CNT_W'(RST_ASSERT_CYC - 1);
  localparam logic [CNT_W-1:0] LD_RAMP   = CNT_W'(RAMP_LEN - 1);
  localparam logic [CNT_W-1:0] LD_RHOLD  = CNT_W'(RST_HOLD - 1);
  localparam logic [CNT_W-1:0] LD_DHOLD  = CNT_W'(DBG_HOLD - 1);
  localparam logic [CNT_W-1:0] RAMP_LEN_W = CNT_W'(RAMP_LEN);

  seq_state_e state_q, state_d;
  // Marks the interval between arst release and the first edge: the first
  // edge is RST_ASSERT cycle 0, so it must load the counter without leaving.
  logic       start_q;

  logic [CNT_W-1:0] hold_cnt;
  logic             hold_tc;
  logic             ld;
  logic [CNT_W-1:0] ld_val;

  logic [CNT_W-1:0]        ramp_idx;
  logic [NUM_CLUSTERS-1:0] ramp_hit;

  logic [NUM_CLUSTERS-1:0] cken_q, cken_d;
  logic grst_l_q, grst_l_d;
  logic gdbg_l_q, gdbg_l_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  ctu_rst_hold_cnt #(.WIDTH(CNT_W)) u_hold_cnt (
    .gclk     (gclk),
    .arst     (arst),
    .ld_i     (ld),
    .ld_val_i (ld_val),
    .cnt_o    (hold_cnt),
    .tc_o     (hold_tc)
  );

  // Ramp cycle index of the *next* cycle: 0 on entry, else RAMP_LEN - count.
  assign ramp_idx = (state_q == ST_CKEN_RAMP) ? (RAMP_LEN_W - hold_cnt) : '0;

  for (genvar gi = 0; gi < NUM_CLUSTERS; gi++) begin : g_ramp_hit
    assign ramp_hit[gi] = (ramp_idx == CNT_W'(gi * CKEN_STAGGER));
  end

  always_comb begin
    state_d = state_q;
    if (pwron_rst_req) begin
      state_d = ST_RST_ASSERT;
    end else begin
      unique case (state_q)
        ST_RST_ASSERT: if (!start_q && hold_tc) state_d = ST_CKEN_RAMP;
        ST_CKEN_RAMP:  if (hold_tc)             state_d = ST_RST_HOLD;
        ST_RST_HOLD:   if (hold_tc)             state_d = ST_RUN;
        ST_RUN: begin
          if (wmr_req)          state_d = ST_WMR;
          else if (dbginit_req) state_d = ST_DBG;
        end
        ST_WMR:        if (hold_tc)             state_d = ST_RUN;
        ST_DBG: begin
          if (wmr_req)      state_d = ST_WMR;
          else if (hold_tc) state_d = ST_RUN;
        end
        default:                                state_d = ST_RST_ASSERT;
      endcase
    end

    // Reload on every state entry; a DBG->WMR hop therefore restarts the hold.
    ld = start_q || pwron_rst_req || (state_d != state_q);
    unique case (state_d)
      ST_RST_ASSERT: ld_val = LD_ASSERT;
      ST_CKEN_RAMP:  ld_val = LD_RAMP;
      ST_RST_HOLD:   ld_val = LD_RHOLD;
      ST_WMR:        ld_val = LD_RHOLD;
      ST_DBG:        ld_val = LD_DHOLD;
      default:       ld_val = '0;
    endcase

    cken_d = cken_q;
    if (state_d == ST_RST_ASSERT) begin
      cken_d = '0;
    end else if (state_d == ST_CKEN_RAMP) begin
      cken_d = cken_q | (ramp_hit & cken_mask);
    end else if (state_q == ST_RUN && state_d == ST_RUN) begin
      cken_d = cken_mask;
    end

    grst_l_d = (state_d == ST_RUN) || (state_d == ST_DBG);
    gdbg_l_d = (state_d == ST_RUN);
    busy_d   = (state_d != ST_RUN);
    done_d   = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  always_ff @(posedge gclk or posedge arst) begin
    if (arst) begin
      state_q  <= ST_RST_ASSERT;
      start_q  <= 1'b1;
      cken_q   <= '0;
      grst_l_q <= 1'b0;
      gdbg_l_q <= 1'b0;
      busy_q   <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_q  <= 1'b0;
      cken_q   <= cken_d;
      grst_l_q <= grst_l_d;
      gdbg_l_q <= gdbg_l_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign cluster_cken = cken_q;
  assign grst_l       = grst_l_q;
  assign gdbginit_l   = gdbg_l_q;
  assign seq_busy     = busy_q;
  assign seq_done     = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ctu_cluster_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_ctu_cluster_rst_seq                                       |
// | Description : Directed self-checking bench for ctu_cluster_rst_seq with   |
// |               NUM_CLUSTERS=4, CKEN_STAGGER=2, RST_HOLD=8, DBG_HOLD=4.     |
// |               Observed vector = {cluster_cken, grst_l, gdbginit_l,        |
// |               seq_busy, seq_done}; cycle n is sampled at the falling edge |
// |               after the n-th rising edge following arst release.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_ctu_cluster_rst_seq;

  logic       gclk = 1'b0;
  logic       arst;
  logic       pwron_rst_req;
  logic       wmr_req;
  logic       dbginit_req;
  logic [3:0] cken_mask;
  logic       grst_l;
  logic       gdbginit_l;
  logic [3:0] cluster_cken;
  logic       seq_busy;
  logic       seq_done;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] obs;
  assign obs = {cluster_cken, grst_l, gdbginit_l, seq_busy, seq_done};

  always #5 gclk = ~gclk;

  ctu_cluster_rst_seq #(
    .NUM_CLUSTERS (4),
    .CKEN_STAGGER (2),
    .RST_HOLD     (8),
    .DBG_HOLD     (4)
  ) dut (
    .gclk          (gclk),
    .arst          (arst),
    .pwron_rst_req (pwron_rst_req),
    .wmr_req       (wmr_req),
    .dbginit_req   (dbginit_req),
    .cken_mask     (cken_mask),
    .grst_l        (grst_l),
    .gdbginit_l    (gdbginit_l),
    .cluster_cken  (cluster_cken),
    .seq_busy      (seq_busy),
    .seq_done      (seq_done)
  );

  // Power-on timing: cken[i] at cycle 4+2i if permitted, release at cycle 20.
  function automatic logic [7:0] exp_pwr(input int c, input logic [3:0] m);
    logic [3:0] ck;
    ck = '0;
    for (int i = 0; i < 4; i++)
      if (m[i] && c >= 4 + 2 * i) ck[i] = 1'b1;
    return {ck, (c >= 20), (c >= 20), (c < 20), (c == 20)};
  endfunction

  task automatic tick();
    @(posedge gclk);
    @(negedge gclk);
  endtask

  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_vec++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  initial begin
    arst          = 1'b1;
    pwron_rst_req = 1'b0;
    wmr_req       = 1'b0;
    dbginit_req   = 1'b0;
    cken_mask     = 4'hF;
    repeat (3) @(negedge gclk);
    chk("reset", obs, 8'b0000_0010);

    // Power-on with all clusters permitted.
    arst = 1'b0;
    for (int c = 0; c <= 22; c++) begin
      tick();
      chk($sformatf("pwr1111 c%0d", c), obs, exp_pwr(c, 4'hF));
    end

    // Warm reset from RUN.
    wmr_req = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      wmr_req = 1'b0;
      chk($sformatf("wmr T+%0d", k), obs,
          (k <= 8) ? 8'b1111_0010 : (k == 9) ? 8'b1111_1101 : 8'b1111_1100);
    end

    // RUN follows mask with one cycle of latency.
    cken_mask = 4'h6;
    tick();
    chk("run mask 0110", obs, 8'b0110_1100);
    cken_mask = 4'hF;
    tick();
    chk("run mask 1111", obs, 8'b1111_1100);

    // Plain debug init.
    dbginit_req = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      dbginit_req = 1'b0;
      chk($sformatf("dbg T+%0d", k), obs,
          (k <= 4) ? 8'b1111_1010 : (k == 5) ? 8'b1111_1101 : 8'b1111_1100);
    end

    // Debug init, then warm reset at T+2; later requests inside WMR ignored.
    dbginit_req = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      dbginit_req = (k == 6);
      wmr_req     = (k == 2) || (k == 5);
      chk($sformatf("dbgwmr T+%0d", k), obs,
          (k <= 2)  ? 8'b1111_1010 :
          (k <= 10) ? 8'b1111_0010 :
          (k == 11) ? 8'b1111_1101 : 8'b1111_1100);
    end
    wmr_req     = 1'b0;
    dbginit_req = 1'b0;

    // Simultaneous power-on and warm reset: power-on wins.
    pwron_rst_req = 1'b1;
    wmr_req       = 1'b1;
    for (int c = 0; c <= 21; c++) begin
      tick();
      pwron_rst_req = 1'b0;
      wmr_req       = 1'b0;
      chk($sformatf("pwron c%0d", c), obs, exp_pwr(c, 4'hF));
    end

    // Fresh power-on, then arst pulse mid-ramp at cycle 7.
    arst = 1'b1;
    @(negedge gclk);
    arst = 1'b0;
    for (int c = 0; c <= 7; c++) begin
      tick();
      chk($sformatf("pre-arst c%0d", c), obs, exp_pwr(c, 4'hF));
    end
    #2 arst = 1'b1;
    #1 chk("arst async", obs, 8'b0000_0010);
    @(negedge gclk);
    cken_mask = 4'hA;
    arst      = 1'b0;
    for (int c = 0; c <= 21; c++) begin
      tick();
      chk($sformatf("pwr1010 c%0d", c), obs, exp_pwr(c, 4'hA));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ctu_cluster_rst_seq.md
CTU_CLUSTER_RST_SEQ -- requirements
Module: ctu_cluster_rst_seq

Interface
REQ-001 Parameter NUM_CLUSTERS, default 8: number of cluster clock headers driven.
REQ-002 Parameter CKEN_STAGGER, default 4: gclk cycles between successive cluster clock enables during ramp.
REQ-003 Parameter RST_HOLD, default 32: gclk cycles grst_l stays low after the ramp, and during warm reset.
REQ-004 Parameter DBG_HOLD, default 16: gclk cycles gdbginit_l stays low for a debug init.
REQ-005 gclk  in  1  sole clock, rising edge.
REQ-006 arst  in  1  reset, asynchronous, active-high.
REQ-007 pwron_rst_req  in  1  one-cycle request for a full power-on sequence.
REQ-008 wmr_req  in  1  one-cycle warm-reset request.
REQ-009 dbginit_req  in  1  one-cycle debug-init request.
REQ-010 cken_mask  in  NUM_CLUSTERS  per-cluster enable permission; 0 keeps that cluster stopped.
REQ-011 grst_l  out  1  global reset to cluster headers, active-low.
REQ-012 gdbginit_l  out  1  global debug init to cluster headers, active-low.
REQ-013 cluster_cken  out  NUM_CLUSTERS  per-cluster clock enable.
REQ-014 seq_busy  out  1  high in every state except RUN.
REQ-015 seq_done  out  1  one-cycle pulse on the first cycle of RUN.

Function
REQ-016 FSM states: RST_ASSERT, CKEN_RAMP, RST_HOLD, RUN, WMR, DBG. All outputs SHALL be registered.
REQ-017 RST_ASSERT: grst_l=0, gdbginit_l=0, cluster_cken all 0; lasts exactly 4 cycles, then CKEN_RAMP.
REQ-018 CKEN_RAMP: lasts NUM_CLUSTERS*CKEN_STAGGER cycles; cluster_cken[i] rises in ramp cycle i*CKEN_STAGGER if cken_mask[i]=1 in that cycle, else stays 0; grst_l and gdbginit_l remain 0.
REQ-019 RST_HOLD: lasts RST_HOLD cycles with grst_l=0, gdbginit_l=0 and cken held, then RUN.
REQ-020 RUN: grst_l=1, gdbginit_l=1; cluster_cken SHALL follow cken_mask with one-cycle latency.
REQ-021 RUN + wmr_req: WMR next cycle; grst_l=0, gdbginit_l=0 for RST_HOLD cycles, cluster_cken unchanged, then RUN with seq_done pulse.
REQ-022 RUN + dbginit_req: DBG next cycle; gdbginit_l=0, grst_l=1 for DBG_HOLD cycles, then RUN with seq_done pulse.
REQ-023 Priority on simultaneous requests: pwron_rst_req > wmr_req > dbginit_req.
REQ-024 pwron_rst_req in any state: RST_ASSERT next cycle with all cluster_cken dropped, full sequence restarts.
REQ-025 wmr_req in DBG: WMR next cycle, with the RST_HOLD count restarted from zero.
REQ-026 wmr_req in WMR, and dbginit_req outside RUN, SHALL be ignored; requests other than pwron_rst_req during RST_ASSERT/CKEN_RAMP/RST_HOLD SHALL be ignored.
REQ-027 Hold counters SHALL be sized for max(RST_HOLD, DBG_HOLD, NUM_CLUSTERS*CKEN_STAGGER) with no wrap before terminal count.

Reset
REQ-028 arst asserted SHALL force asynchronously: state RST_ASSERT, counters 0, grst_l=0, gdbginit_l=0, cluster_cken=0, seq_busy=1, seq_done=0.
REQ-029 On arst deassertion the power-on sequence SHALL start automatically; the first clock edge is RST_ASSERT cycle 0.
REQ-030 arst mid-operation, including mid-ramp, SHALL abandon the sequence with no partial enables surviving.

Structure
REQ-031 Package ctu_rst_pkg SHALL hold the state enum and the constant RST_ASSERT_CYC=4.
REQ-032 A single sub-module ctu_rst_hold_cnt (loadable down-counter with terminal-count flag) SHALL be used for all hold and ramp timing.

Verification (NUM_CLUSTERS=4, CKEN_STAGGER=2, RST_HOLD=8, DBG_HOLD=4; cycles counted from the first edge after arst release)
REQ-033 cken_mask=4'b1111 -> cluster_cken bits rise at cycles 4,6,8,10; grst_l=gdbginit_l=1 and seq_done=1 at cycle 20 only.
REQ-034 cken_mask=4'b1010 -> cken[1] at cycle 6, cken[3] at cycle 10, cken[0] and cken[2] stay 0; grst_l still rises at cycle 20.
REQ-035 RUN, wmr_req pulse at cycle T -> grst_l=gdbginit_l=0 during cycles T+1..T+8, cken unchanged, release plus seq_done at T+9.
REQ-036 RUN, dbginit_req at T, wmr_req at T+2 -> gdbginit_l low from T+1, grst_l low T+3..T+10, both high at T+11.
REQ-037 RUN, pwron_rst_req and wmr_req in the same cycle -> all cken 0 next cycle, full sequence repeats with REQ-033 timing.
REQ-038 arst pulse at cycle 7, mid-ramp -> cluster_cken=0 and grst_l=0 immediately, without waiting for gclk; after release, REQ-033 timing from the new release.
